// File: rtl/image_xform_engine.sv
// rtl/image_xform_engine.sv - one-pixel-per-clock frame copy with optional h/v mirror and colour invert
module image_xform_engine #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [2:0]        mode_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic [PIX_W-1:0]  rd_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [PIX_W-1:0]  wr_data_o
);

  localparam logic [ADDR_W-1:0] W_A        = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] WM1_A      = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] HM1_A      = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_A = ADDR_W'((IMG_H - 1) * IMG_W);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state_q;
  logic [2:0]        mode_q;
  logic [ADDR_W-1:0] x_q, y_q, rowb_q, dst_q, rd_addr_q, wr_addr_q;
  logic              rd_en_q, wr_en_q, busy_q, done_q;

  logic              row_end, last_pix;
  logic [ADDR_W-1:0] x_d, y_d, rowb_d, dst_d, start_rowb, start_dst;

  // rowb tracks dy*IMG_W incrementally so the destination needs no multiplier
  always_comb begin
    row_end    = (x_q == WM1_A);
    last_pix   = row_end && (y_q == HM1_A);
    x_d        = row_end ? '0 : x_q + 1'b1;
    y_d        = row_end ? y_q + 1'b1 : y_q;
    rowb_d     = !row_end ? rowb_q : (mode_q[1] ? rowb_q - W_A : rowb_q + W_A);
    dst_d      = rowb_d + (mode_q[0] ? WM1_A - x_d : x_d);
    start_rowb = mode_i[1] ? LAST_ROW_A : '0;
    start_dst  = start_rowb + (mode_i[0] ? WM1_A : '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rowb_q    <= '0;
      dst_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q   <= rd_en_q;
      wr_addr_q <= dst_q;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q    <= mode_i;
            x_q       <= '0;
            y_q       <= '0;
            rowb_q    <= start_rowb;
            dst_q     <= start_dst;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end
        RUN: begin
          if (last_pix) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            rowb_q    <= rowb_d;
            dst_q     <= dst_d;
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = rd_addr_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  // read data arrives one cycle after rd_en, aligned with wr_en, so it is passed straight through
  assign wr_data_o = wr_en_q ? (rd_data_i ^ {PIX_W{mode_q[2]}}) : '0;

endmodule

// File: tb/tb_image_xform_engine.sv
// tb/tb_image_xform_engine.sv - scoreboard bench for image_xform_engine (4x3 and 320x240 instances)
module tb_image_xform_engine;

  localparam int SW = 4;
  localparam int SH = 3;
  localparam int NS = SW * SH;
  localparam int LW = 320;
  localparam int LH = 240;
  localparam int NL = LW * LH;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic clk;
  logic reset_n;

  logic        s_start, s_busy, s_done, s_rd_en, s_wr_en;
  logic [2:0]  s_mode;
  logic [16:0] s_rd_addr, s_wr_addr;
  logic [7:0]  s_rd_data, s_wr_data;

  logic        l_start, l_busy, l_done, l_rd_en, l_wr_en;
  logic [2:0]  l_mode;
  logic [16:0] l_rd_addr, l_wr_addr;
  logic [7:0]  l_rd_data, l_wr_data;

  logic [7:0] s_src [0:15];
  logic [7:0] s_dst [0:15];
  int         s_wcnt [0:15];
  wr_t        sq[$];
  wr_t        lq[$];

  int checks;
  int failures;

  image_xform_engine #(.IMG_W(SW), .IMG_H(SH), .PIX_W(8), .ADDR_W(17)) dut_s (
    .clk(clk), .reset_n(reset_n), .start_i(s_start), .mode_i(s_mode),
    .busy_o(s_busy), .done_o(s_done), .rd_en_o(s_rd_en), .rd_addr_o(s_rd_addr),
    .rd_data_i(s_rd_data), .wr_en_o(s_wr_en), .wr_addr_o(s_wr_addr), .wr_data_o(s_wr_data)
  );

  image_xform_engine #(.IMG_W(LW), .IMG_H(LH), .PIX_W(8), .ADDR_W(17)) dut_l (
    .clk(clk), .reset_n(reset_n), .start_i(l_start), .mode_i(l_mode),
    .busy_o(l_busy), .done_o(l_done), .rd_en_o(l_rd_en), .rd_addr_o(l_rd_addr),
    .rd_data_i(l_rd_data), .wr_en_o(l_wr_en), .wr_addr_o(l_wr_addr), .wr_data_o(l_wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lsrc(input int a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic int exp_dest(input int w, input int h, input logic [2:0] m, input int i);
    int x, y, dx, dy;
    x  = i % w;
    y  = i / w;
    dx = m[0] ? (w - 1 - x) : x;
    dy = m[1] ? (h - 1 - y) : y;
    return dy * w + dx;
  endfunction

  always @(posedge clk) if (s_rd_en) s_rd_data <= s_src[s_rd_addr[3:0]];
  always @(posedge clk) if (l_rd_en) l_rd_data <= lsrc(int'(l_rd_addr));

  task automatic frame_small(input logic [2:0] m, input int ra, input int rb, input int tc);
    wr_t e;
    logic exp_rd, exp_wr, exp_busy, exp_done;
    for (int i = 0; i < 16; i++) begin
      s_wcnt[i] = 0;
      s_dst[i]  = 8'h00;
    end
    sq.delete();
    for (int i = 0; i < NS; i++) begin
      e.addr = exp_dest(SW, SH, m, i);
      e.data = m[2] ? ~s_src[i] : s_src[i];
      sq.push_back(e);
    end
    @(negedge clk);
    s_mode  = m;
    s_start = 1'b1;
    for (int c = 1; c <= NS + 4; c++) begin
      @(negedge clk);
      exp_rd   = (c <= NS);
      exp_wr   = (c >= 2) && (c <= NS + 1);
      exp_busy = (c <= NS + 1);
      exp_done = (c == NS + 2);
      checks += 4;
      if (s_rd_en !== exp_rd) begin failures++; $display("FAIL rd_en mode=%b cycle=%0d got=%b exp=%b", m, c, s_rd_en, exp_rd); end
      if (s_wr_en !== exp_wr) begin failures++; $display("FAIL wr_en mode=%b cycle=%0d got=%b exp=%b", m, c, s_wr_en, exp_wr); end
      if (s_busy !== exp_busy) begin failures++; $display("FAIL busy mode=%b cycle=%0d got=%b exp=%b", m, c, s_busy, exp_busy); end
      if (s_done !== exp_done) begin failures++; $display("FAIL done mode=%b cycle=%0d got=%b exp=%b", m, c, s_done, exp_done); end
      if (s_rd_en === 1'b1 && exp_rd) begin
        checks++;
        if (s_rd_addr !== 17'(c - 1)) begin failures++; $display("FAIL rd_addr cycle=%0d got=%0d exp=%0d", c, s_rd_addr, c - 1); end
      end
      if (s_wr_en === 1'b1) begin
        checks++;
        if (sq.size() == 0) begin
          failures++;
          $display("FAIL wr_unexpected cycle=%0d got_addr=%0d exp=none", c, s_wr_addr);
        end else begin
          e = sq.pop_front();
          if (s_wr_addr !== 17'(e.addr) || s_wr_data !== e.data) begin
            failures++;
            $display("FAIL wr_beat mode=%b cycle=%0d got=%0d/%h exp=%0d/%h", m, c, s_wr_addr, s_wr_data, e.addr, e.data);
          end
          s_dst[s_wr_addr[3:0]] = s_wr_data;
          s_wcnt[s_wr_addr[3:0]]++;
        end
      end
      s_start = (c == ra) || (c == rb);
      if (c == tc) s_mode = ~m;
    end
    s_start = 1'b0;
    checks++;
    if (sq.size() != 0) begin failures++; $display("FAIL sb_left mode=%b got=%0d exp=0", m, sq.size()); end
    for (int i = 0; i < NS; i++) begin
      checks++;
      if (s_wcnt[i] != 1) begin failures++; $display("FAIL wr_once addr=%0d got=%0d exp=1", i, s_wcnt[i]); end
    end
  endtask

  task automatic chk_dst(input string name, input int a, input logic [7:0] exp);
    checks++;
    if (s_dst[a] !== exp) begin failures++; $display("FAIL %s dest[%0d] got=%h exp=%h", name, a, s_dst[a], exp); end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 2;
    if ({s_busy, s_done, s_rd_en, s_wr_en} !== 4'b0 || s_rd_addr !== 17'd0 || s_wr_addr !== 17'd0 || s_wr_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_small got=%b%b%b%b/%0d/%0d/%h exp=0", s_busy, s_done, s_rd_en, s_wr_en, s_rd_addr, s_wr_addr, s_wr_data);
    end
    if ({l_busy, l_done, l_rd_en, l_wr_en} !== 4'b0 || l_rd_addr !== 17'd0 || l_wr_addr !== 17'd0 || l_wr_data !== 8'd0) begin
      failures++;
      $display("FAIL reset_large got=%b%b%b%b/%0d/%0d/%h exp=0", l_busy, l_done, l_rd_en, l_wr_en, l_rd_addr, l_wr_addr, l_wr_data);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_identity;
    frame_small(3'b000, 0, 0, 0);
    for (int i = 0; i < NS; i++) chk_dst("identity", i, 8'(i));
  endtask

  task automatic test_flips;
    frame_small(3'b001, 0, 0, 0);
    chk_dst("flip_h", 3, 8'd0);
    chk_dst("flip_h", 0, 8'd3);
    chk_dst("flip_h", 7, 8'd4);
    frame_small(3'b010, 0, 0, 0);
    chk_dst("flip_v", 8, 8'd0);
    chk_dst("flip_v", 0, 8'd8);
    frame_small(3'b011, 0, 0, 0);
    chk_dst("flip_hv", 11, 8'd0);
    chk_dst("flip_hv", 0, 8'd11);
  endtask

  task automatic test_invert;
    s_src[5] = 8'h5A;
    frame_small(3'b100, 0, 0, 0);
    chk_dst("invert", 5, 8'hA5);
    chk_dst("invert", 0, 8'hFF);
    chk_dst("invert", 11, 8'hF4);
    s_src[5] = 8'd5;
  endtask

  task automatic test_back_to_back;
    frame_small(3'b001, 3, 13, 5);
    chk_dst("restart_ignored", 3, 8'd0);
    chk_dst("restart_ignored", 7, 8'd4);
    frame_small(3'b110, 0, 0, 0);
    chk_dst("back_to_back", 8, 8'hFF);
  endtask

  task automatic test_reset_midframe;
    @(negedge clk);
    s_mode  = 3'b000;
    s_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      s_start = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({s_busy, s_rd_en, s_wr_en, s_done} !== 4'b0) begin
      failures++;
      $display("FAIL reset_midframe busy/rd/wr/done got=%b%b%b%b exp=0000", s_busy, s_rd_en, s_wr_en, s_done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (s_done !== 1'b0 || s_busy !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle cycle=%0d got done=%b busy=%b exp=0", c, s_done, s_busy);
      end
    end
    frame_small(3'b000, 0, 0, 0);
    chk_dst("after_reset", 6, 8'd6);
  endtask

  task automatic test_full_frame;
    wr_t e;
    int  bad, rd_cnt, wr_cnt, wr_idx, done_cyc, a0, a319;
    logic exp_rd, exp_wr;
    bad = 0; rd_cnt = 0; wr_cnt = 0; wr_idx = 0; done_cyc = -1; a0 = -1; a319 = -1;
    lq.delete();
    for (int i = 0; i < NL; i++) begin
      e.addr = exp_dest(LW, LH, 3'b111, i);
      e.data = ~lsrc(i);
      lq.push_back(e);
    end
    @(negedge clk);
    l_mode  = 3'b111;
    l_start = 1'b1;
    for (int c = 1; c <= NL + 4; c++) begin
      @(negedge clk);
      l_start = 1'b0;
      exp_rd  = (c <= NL);
      exp_wr  = (c >= 2) && (c <= NL + 1);
      if (l_rd_en !== exp_rd || l_wr_en !== exp_wr || l_busy !== (c <= NL + 1)) bad++;
      if (l_rd_en === 1'b1) begin
        rd_cnt++;
        if (l_rd_addr !== 17'(c - 1)) bad++;
      end
      if (l_done === 1'b1) done_cyc = c;
      if (l_wr_en === 1'b1) begin
        wr_cnt++;
        if (wr_idx == 0) a0 = int'(l_wr_addr);
        if (wr_idx == 319) a319 = int'(l_wr_addr);
        wr_idx++;
        if (lq.size() == 0) bad++;
        else begin
          e = lq.pop_front();
          if (l_wr_addr !== 17'(e.addr) || l_wr_data !== e.data) bad++;
        end
      end
    end
    checks += 6;
    if (bad != 0) begin failures++; $display("FAIL full_frame_beats got=%0d bad exp=0", bad); end
    if (rd_cnt != NL) begin failures++; $display("FAIL full_frame_reads got=%0d exp=%0d", rd_cnt, NL); end
    if (wr_cnt != NL) begin failures++; $display("FAIL full_frame_writes got=%0d exp=%0d", wr_cnt, NL); end
    if (done_cyc != NL + 2) begin failures++; $display("FAIL full_frame_done_cycle got=%0d exp=%0d", done_cyc, NL + 2); end
    if (a0 != 76799) begin failures++; $display("FAIL full_frame_src0 got=%0d exp=76799", a0); end
    if (a319 != 76480) begin failures++; $display("FAIL full_frame_src319 got=%0d exp=76480", a319); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    s_start  = 1'b0;
    s_mode   = 3'b000;
    l_start  = 1'b0;
    l_mode   = 3'b000;
    for (int i = 0; i < 16; i++) s_src[i] = 8'(i);
    test_reset;
    test_identity;
    test_flips;
    test_invert;
    test_back_to_back;
    test_reset_midframe;
    test_full_frame;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
